tansig_output_argmax: RTL and testbench
=======================================

Name: tansig_output_argmax

Overview:
- Final classification stage of the ASR network. It sits directly downstream of the output-layer tansigmoid activation.
- Accepts one IEEE-754 single-precision activation per neuron, serially. Tracks the running maximum.
- After NUM_CLASSES samples, reports the winning class index, its value, and a rejection flag when confidence is below threshold.

Parameters:
- DATA_WIDTH, 32, activation word width; IEEE-754 single only, not to be overridden.
- NUM_CLASSES, 10, output-layer neurons (vocabulary words) per frame.
- IDX_W, 4, width of result_index; must satisfy 2^IDX_W >= NUM_CLASSES.
- REJECT_THRESHOLD, 32'h3F000000, reject limit (0.5); result rejected when max <= threshold.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; clears and begins a new frame.
- in_valid  input  1  in_data valid this cycle.
- in_data  input  32  tansigmoid activation, IEEE-754 single.
- in_ready  output  1  block accepts a sample this cycle.
- busy  output  1  high while in ACCUM.
- result_valid  output  1  one-cycle pulse; result fields updated.
- result_index  output  IDX_W  index of winning neuron (0-based, arrival order).
- result_value  output  32  winning activation, after zero flush.
- result_reject  output  1  1 when winning value <= REJECT_THRESHOLD, or no valid sample in the frame.
- nan_seen  output  1  at least one NaN sample occurred in the reported frame.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - Sample counter, best register and best-valid flag clear.
  - All outputs go to 0, including in_ready, busy, result_* and nan_seen.
- States: IDLE, ACCUM, DONE.
  - IDLE: in_ready=0; samples are ignored. start=1 -> ACCUM.
  - ACCUM: in_ready=1, busy=1.
    - Accept = in_valid & in_ready.
    - On every accept, the counter increments.
    - An accept with counter==NUM_CLASSES-1 -> DONE.
  - DONE: lasts exactly one cycle. result_valid=1 with the registered result. Next state is IDLE.
- Start handling:
  - start has priority in every state. Counter, best and NaN flag clear, and next state is ACCUM.
  - start in ACCUM aborts the frame silently; no result is produced.
  - start in DONE still emits that cycle's result_valid, then moves to ACCUM.
- Latency: result_valid asserts on the cycle after the NUM_CLASSES-th accept.
- Result hold: result_index, result_value, result_reject and nan_seen are registered. They hold until the next result_valid.
- Float handling for every accepted sample:
  - Zero flush: exponent==0 (zero or denormal) is replaced by +0 (32'h00000000), regardless of sign.
  - NaN: exponent==8'hFF and mantissa!=0. Never a candidate. Sets the frame's NaN flag. Still counts toward NUM_CLASSES.
  - Infinities are ordinary candidates.
- Ordering key (unsigned 32-bit compare of the flushed word x):
  - sign=0: key = {1'b1, x[30:0]}.
  - sign=1: key = ~x.
- Best update: when no best is held yet, or key(sample) > key(best) strictly. Ties keep the lower index.
- Threshold: result_reject = !(key(best) > key(REJECT_THRESHOLD)). If all samples are NaN: result_index=0, result_value=0, result_reject=1.
- Pacing: in_valid may drop for any number of cycles within a frame. Counting is by accepts only.

Test Plan:
- Scenario 1, basic win:
  - Stimulus: start, then 10 back-to-back samples, 0.1 (3DCCCCCD) everywhere except index 7 = 0.9 (3F666666).
  - Response: result_valid on cycle after 10th accept; index 7, value 3F666666, reject 0, nan_seen 0.
- Scenario 2, tie:
  - Stimulus: 0.75 (3F400000) at indices 2 and 5; all others -0.5.
  - Response: index 2, reject 0.
- Scenario 3, all negative:
  - Stimulus: max -0.25 (BE800000) at index 4; others -0.9 (BF666666).
  - Response: index 4, value BE800000, reject 1.
- Scenario 4, NaN and signed zero:
  - Stimulus: index 3 = 7FC00000; index 0 = -0.0 (80000000); index 6 = denormal 00000001; others negative.
  - Response: nan_seen 1; index 0, value 00000000, reject 1.
- Scenario 5, abort and reset:
  - Stimulus A: start, 4 samples, start again, 10 new samples.
  - Response A: exactly one result_valid, from the second frame.
  - Stimulus B: rst_n low mid-frame.
  - Response B: all outputs 0 immediately; no result after release without a new start.
- Scenario 6, pacing:
  - Stimulus: samples with in_valid gaps of 0–3 cycles; in_valid high in IDLE before start.
  - Response: IDLE samples ignored (in_ready=0); result identical to the gap-free run; busy high exactly during ACCUM.

Source files
------------

// File: rtl/tansig_output_argmax_if.sv
// Sample-in / result-out bundle for the tansig output argmax stage.
// The master drives start and samples; the slave returns handshake and result.
interface tansig_output_argmax_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_W      = 4
);
  logic                  start;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  busy;
  logic                  result_valid;
  logic [IDX_W-1:0]      result_index;
  logic [DATA_WIDTH-1:0] result_value;
  logic                  result_reject;
  logic                  nan_seen;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, busy, result_valid, result_index, result_value,
           result_reject, nan_seen
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, busy, result_valid, result_index, result_value,
           result_reject, nan_seen
  );
endinterface

// File: rtl/tansig_output_argmax.sv
// Serial argmax over one frame of IEEE-754 single activations, with zero
// flush, NaN exclusion and a confidence-threshold rejection flag.
module tansig_output_argmax #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned NUM_CLASSES      = 10,
  parameter int unsigned IDX_W            = 4,
  parameter logic [31:0] REJECT_THRESHOLD = 32'h3F000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tansig_output_argmax_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  // Monotonic unsigned key: positives above negatives, negatives reversed.
  function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] x);
    return x[31] ? ~x : {1'b1, x[30:0]};
  endfunction

  localparam logic [DATA_WIDTH-1:0] THR_KEY = REJECT_THRESHOLD[31] ? ~REJECT_THRESHOLD
                                              : {1'b1, REJECT_THRESHOLD[30:0]};
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] best_q, best_d;
  logic [IDX_W-1:0]      best_idx_q, best_idx_d;
  logic                  best_vld_q, best_vld_d;
  logic                  nan_q, nan_d;

  logic                  in_ready_d, busy_d, res_valid_d;
  logic                  res_load;
  logic [IDX_W-1:0]      res_index_d;
  logic [DATA_WIDTH-1:0] res_value_d;
  logic                  res_reject_d, res_nan_d;

  logic                  accept, last, is_nan, take;
  logic [DATA_WIDTH-1:0] flushed;
  logic                  fin_vld;
  logic [DATA_WIDTH-1:0] fin_val;

  // Sample classification for the word currently on in_data.
  always_comb begin
    accept  = (state_q == ACCUM) && bus.in_valid;
    last    = (cnt_q == LAST_IDX);
    is_nan  = (bus.in_data[30:23] == 8'hFF) && (bus.in_data[22:0] != 23'd0);
    flushed = (bus.in_data[30:23] == 8'd0) ? '0 : bus.in_data;
    take    = accept && !is_nan &&
              (!best_vld_q || (order_key(flushed) > order_key(best_q)));
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      best_q            <= '0;
      best_idx_q        <= '0;
      best_vld_q        <= 1'b0;
      nan_q             <= 1'b0;
      bus.in_ready      <= 1'b0;
      bus.busy          <= 1'b0;
      bus.result_valid  <= 1'b0;
      bus.result_index  <= '0;
      bus.result_value  <= '0;
      bus.result_reject <= 1'b0;
      bus.nan_seen      <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      best_q           <= best_d;
      best_idx_q       <= best_idx_d;
      best_vld_q       <= best_vld_d;
      nan_q            <= nan_d;
      bus.in_ready     <= in_ready_d;
      bus.busy         <= busy_d;
      bus.result_valid <= res_valid_d;
      if (res_load) begin
        bus.result_index  <= res_index_d;
        bus.result_value  <= res_value_d;
        bus.result_reject <= res_reject_d;
        bus.nan_seen      <= res_nan_d;
      end
    end
  end

  // Next-state logic; start overrides every state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = IDLE;
      ACCUM:   if (accept && last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.start) state_d = ACCUM;
  end

  // Datapath updates and registered-output next values.
  always_comb begin
    cnt_d      = cnt_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    best_vld_d = best_vld_q;
    nan_d      = nan_q;

    if (bus.start) begin
      cnt_d      = '0;
      best_d     = '0;
      best_idx_d = '0;
      best_vld_d = 1'b0;
      nan_d      = 1'b0;
    end else if (accept) begin
      cnt_d = last ? '0 : cnt_q + IDX_W'(1);
      nan_d = nan_q | is_nan;
      if (take) begin
        best_d     = flushed;
        best_idx_d = cnt_q;
        best_vld_d = 1'b1;
      end
    end

    // Result folds in the final sample combinationally so it is ready in DONE.
    fin_vld      = best_vld_q || take;
    fin_val      = take ? flushed : best_q;
    res_load     = accept && last && !bus.start;
    res_index_d  = fin_vld ? (take ? cnt_q : best_idx_q) : '0;
    res_value_d  = fin_vld ? fin_val : '0;
    res_reject_d = !fin_vld || !(order_key(fin_val) > THR_KEY);
    res_nan_d    = nan_q | is_nan;

    in_ready_d  = (state_d == ACCUM);
    busy_d      = (state_d == ACCUM);
    res_valid_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_tansig_output_argmax.sv
// Directed bench for tansig_output_argmax: real-valued frame model, per-cycle
// compare against it, and literal expectations per scenario.
module tb_tansig_output_argmax;
  localparam int unsigned N = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rv_count = 0;

  tansig_output_argmax_if #(.DATA_WIDTH(32), .IDX_W(4)) bus ();

  tansig_output_argmax dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Value of a flushed, non-NaN single as a real; infinities as huge magnitudes.
  function automatic real to_real(input logic [31:0] w);
    int  e;
    real m;
    e = int'(w[30:23]);
    if (e == 0) return 0.0;
    if (e == 255) return w[31] ? -1.0e300 : 1.0e300;
    m = 1.0 + real'(w[22:0]) / 8388608.0;
    m = m * (2.0 ** real'(e - 127));
    return w[31] ? -m : m;
  endfunction

  task automatic model_result(input logic [31:0] q[$], output logic [3:0] idx,
                              output logic [31:0] val, output logic rej, output logic nan);
    bit  have;
    real bv;
    logic [31:0] w;
    have = 0; bv = 0.0; idx = 0; val = 0; nan = 0;
    foreach (q[i]) begin
      w = q[i];
      if (w[30:23] == 8'hFF && w[22:0] != 0) begin
        nan = 1;
      end else begin
        if (w[30:23] == 8'h00) w = 32'h0;
        if (!have || to_real(w) > bv) begin
          have = 1; bv = to_real(w); val = w; idx = 4'(i);
        end
      end
    end
    rej = !have || !(bv > 0.5);
  endtask

  // Frame-level behavioural model advanced on every clock.
  int          m_phase = 0;  // 0 idle, 1 collecting, 2 reporting
  logic [31:0] m_q[$];
  logic [3:0]  exp_idx = 0;
  logic [31:0] exp_val = 0;
  logic        exp_rej = 0, exp_nan = 0, exp_rv = 0, exp_busy = 0;

  always @(posedge clk or negedge rst_n) begin : model
    bit acc;
    if (!rst_n) begin
      m_phase = 0; m_q.delete();
      exp_idx = 0; exp_val = 0; exp_rej = 0; exp_nan = 0; exp_rv = 0; exp_busy = 0;
    end else begin
      acc = (m_phase == 1) && bus.in_valid;
      if (bus.start) begin
        m_q.delete(); m_phase = 1;
      end else if (acc) begin
        m_q.push_back(bus.in_data);
        if (m_q.size() == N) begin
          model_result(m_q, exp_idx, exp_val, exp_rej, exp_nan);
          m_phase = 2;
        end
      end else if (m_phase == 2) begin
        m_phase = 0;
      end
      exp_rv   = (m_phase == 2);
      exp_busy = (m_phase == 1);
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 32'(bus.in_ready), 32'(exp_busy));
    chk("busy", 32'(bus.busy), 32'(exp_busy));
    chk("result_valid", 32'(bus.result_valid), 32'(exp_rv));
    chk("result_index", 32'(bus.result_index), 32'(exp_idx));
    chk("result_value", bus.result_value, exp_val);
    chk("result_reject", 32'(bus.result_reject), 32'(exp_rej));
    chk("nan_seen", 32'(bus.nan_seen), 32'(exp_nan));
    if (bus.result_valid) rv_count++;
  end

  logic [31:0] fr [N];

  task automatic fill(input logic [31:0] base);
    foreach (fr[i]) fr[i] = base;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input int gap);
    repeat (gap) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 32'hDEADBEEF;
  endtask

  task automatic run_frame(input logic [31:0] f [N], input bit gaps, input string name,
                           input logic [3:0] e_idx, input logic [31:0] e_val,
                           input logic e_rej, input logic e_nan);
    int waited;
    pulse_start();
    for (int i = 0; i < N; i++) send(f[i], gaps ? (i % 4) : 0);
    chk({name, "_latency"}, 32'(bus.result_valid), 32'd1);
    waited = 0;
    while (!bus.result_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({name, "_idx"}, 32'(bus.result_index), 32'(e_idx));
    chk({name, "_val"}, bus.result_value, e_val);
    chk({name, "_rej"}, 32'(bus.result_reject), 32'(e_rej));
    chk({name, "_nan"}, 32'(bus.nan_seen), 32'(e_nan));
  endtask

  initial begin
    int c0;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_result_valid", 32'(bus.result_valid), 32'd0);
    chk("reset_result_value", bus.result_value, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic win, then a tie, back to back so the second start lands in DONE.
    fill(32'h3DCCCCCD); fr[7] = 32'h3F666666;
    run_frame(fr, 0, "basic", 4'd7, 32'h3F666666, 1'b0, 1'b0);
    fill(32'hBF000000); fr[2] = 32'h3F400000; fr[5] = 32'h3F400000;
    run_frame(fr, 0, "tie", 4'd2, 32'h3F400000, 1'b0, 1'b0);
    fill(32'hBF666666); fr[4] = 32'hBE800000;
    run_frame(fr, 0, "all_neg", 4'd4, 32'hBE800000, 1'b1, 1'b0);
    fill(32'hBF000000); fr[3] = 32'h7FC00000; fr[0] = 32'h80000000; fr[6] = 32'h00000001;
    run_frame(fr, 0, "nan_zero", 4'd0, 32'h00000000, 1'b1, 1'b1);
    fill(32'h3F000000); fr[9] = 32'h7F800000;
    run_frame(fr, 0, "pos_inf", 4'd9, 32'h7F800000, 1'b0, 1'b0);
    fill(32'h3F000000);
    run_frame(fr, 0, "at_thresh", 4'd0, 32'h3F000000, 1'b1, 1'b0);
    fill(32'hBF000000); fr[8] = 32'h3F000001;
    run_frame(fr, 0, "above_thresh", 4'd8, 32'h3F000001, 1'b0, 1'b0);
    fill(32'h7FC00000); fr[5] = 32'hFF800001;
    run_frame(fr, 0, "all_nan", 4'd0, 32'h00000000, 1'b1, 1'b1);
    fill(32'hFF800000);
    run_frame(fr, 0, "neg_inf", 4'd0, 32'hFF800000, 1'b1, 1'b0);
    repeat (3) @(negedge clk);

    // Abort: four samples then a fresh start; only the second frame reports.
    c0 = rv_count;
    pulse_start();
    for (int i = 0; i < 4; i++) send(32'h3F7FFFFF, 0);
    fill(32'h3DCCCCCD); fr[1] = 32'h3F333333;
    run_frame(fr, 0, "abort", 4'd1, 32'h3F333333, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("abort_one_result", 32'(rv_count - c0), 32'd1);

    // Asynchronous reset mid-frame, then no result without a start.
    pulse_start();
    for (int i = 0; i < 3; i++) send(32'h3F400000, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_in_ready", 32'(bus.in_ready), 32'd0);
    chk("async_busy", 32'(bus.busy), 32'd0);
    chk("async_result_index", 32'(bus.result_index), 32'd0);
    chk("async_result_value", bus.result_value, 32'd0);
    chk("async_nan_seen", 32'(bus.nan_seen), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    c0 = rv_count;
    bus.in_valid = 1'b1; bus.in_data = 32'h3F400000;
    repeat (15) @(negedge clk);
    bus.in_valid = 1'b0;
    chk("post_reset_no_result", 32'(rv_count - c0), 32'd0);
    chk("post_reset_busy", 32'(bus.busy), 32'd0);

    // Pacing: valid held high in IDLE, then the basic frame with gaps.
    bus.in_valid = 1'b1; bus.in_data = 32'h7F7FFFFF;
    repeat (5) @(negedge clk);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    fill(32'h3DCCCCCD); fr[7] = 32'h3F666666;
    run_frame(fr, 1, "paced", 4'd7, 32'h3F666666, 1'b0, 1'b0);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
